// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_reg_bank
// Description : Parametrised AXI4-Lite slave register bank. Read/write
//               registers with byte enables, read-only status registers
//               sourced from status_in, per-register write pulses, and
//               SLVERR on out-of-range or read-only writes.
// Ports       : ACLK/ARESET       clock, asynchronous active-high reset
//               AW*/W*/B*         AXI4-Lite write address/data/response
//               AR*/R*            AXI4-Lite read address/data
//               ctrl_regs         flat register contents (RO slices read 0)
//               status_in         status values for read-only registers
//               wr_pulse          one-cycle pulse per committed register
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int         STRB_W = DATA_WIDTH / 8;
  localparam int         LSB    = $clog2(STRB_W);
  localparam int         IDX_W  = ADDR_WIDTH - LSB;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t                    w_state, w_state_nxt;
  r_state_t                    r_state, r_state_nxt;
  logic                        aw_held, w_held, commit, w_ok;
  logic [IDX_W-1:0]            w_idx, ar_idx;
  logic [DATA_WIDTH-1:0]       w_data, rd_val;
  logic [STRB_W-1:0]           w_strb;
  logic [NUM_REGS-1:0]         pulse_nxt;
  logic [NUM_REGS*DATA_WIDTH-1:0] rd_src;
  logic                        rd_hit;
  logic                        unused_inputs;

  // Protection bits, sub-word address bits and RW status slices carry no meaning here.
  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[LSB-1:0], ARADDR[LSB-1:0], status_in};

  // ---------------- write channel ----------------
  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = !aw_held;
        WREADY  = !w_held;
        if (aw_held && w_held) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // A write is accepted only for an existing, writable register.
  always_comb begin
    w_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i) && !RO_MASK[i]) w_ok = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      w_idx    <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      BRESP    <= OKAY;
      wr_pulse <= '0;
    end else begin
      w_state  <= w_state_nxt;
      wr_pulse <= pulse_nxt;
      if (AWVALID && AWREADY) begin
        aw_held <= 1'b1;
        w_idx   <= AWADDR[ADDR_WIDTH-1:LSB];
      end
      if (WVALID && WREADY) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      // READY flags stay low through W_RESP by state, so held flags can clear now.
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BRESP   <= w_ok ? OKAY : SLVERR;
      end
    end
  end

  // ---------------- register storage ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [IDX_W-1:0] REG_IDX = IDX_W'(i);
    if (RO_MASK[i]) begin : g_ro
      assign pulse_nxt[i]                          = 1'b0;
      assign ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      assign rd_src[i*DATA_WIDTH +: DATA_WIDTH]    = status_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] value;
      logic                  hit;
      assign hit          = commit && (w_idx == REG_IDX);
      assign pulse_nxt[i] = hit;
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          value <= RESET_VAL;
        end else if (hit) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb[k]) value[k*8 +: 8] <= w_data[k*8 +: 8];
          end
        end
      end
      assign ctrl_regs[i*DATA_WIDTH +: DATA_WIDTH] = value;
      assign rd_src[i*DATA_WIDTH +: DATA_WIDTH]    = value;
    end
  end

  // ---------------- read channel ----------------
  assign ar_idx = ARADDR[ADDR_WIDTH-1:LSB];

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_val = rd_src[i*DATA_WIDTH +: DATA_WIDTH];
        rd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Sampling on the handshake edge returns the pre-edge value, so a read
  // coinciding with a write commit sees the old contents.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      RDATA   <= '0;
      RRESP   <= OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ARVALID && ARREADY) begin
        RDATA <= rd_val;
        RRESP <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

endmodule
`default_nettype wire
